bus_fabric: RTL

- Parametrised system-bus fabric between the 6502 core and up to 2^SLOT_BITS peripheral slots.
- Decodes the top address bits into one-hot chip selects.
- Inserts per-slot configurable wait states by driving the CPU RDY line.
- Commits each write exactly once, returns read data through a registered slot-select mux, and flags accesses to unmapped slots.

---
 rtl/bus_fabric.sv | 87 ++++++++
 1 files changed

// File: rtl/bus_fabric.sv
// bus_fabric: 6502 system-bus fabric with slot decode, per-slot wait states, write commit, read mux and error capture.
module bus_fabric #(
    parameter int AW = 16,
    parameter int DW = 8,
    parameter int SLOT_BITS = 4,
    parameter logic [2**SLOT_BITS-1:0] SLOT_EN = 16'h8007,
    parameter logic [2**SLOT_BITS*4-1:0] WAIT_CFG = '0,
    parameter logic [DW-1:0] UNMAPPED_DATA = 8'hFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [AW-1:0]                cpu_ab,
    input  logic                         cpu_we,
    input  logic [DW-1:0]                cpu_do,
    input  logic                         hold_in,
    output logic                         cpu_rdy,
    output logic [DW-1:0]                cpu_di,
    output logic [2**SLOT_BITS-1:0]      slot_cs,
    output logic                         slot_we,
    output logic [AW-SLOT_BITS-1:0]      slot_ab,
    output logic [DW-1:0]                slot_wdata,
    input  logic [2**SLOT_BITS*DW-1:0]   slot_rdata,
    output logic                         bus_err,
    output logic [AW-1:0]                err_addr,
    output logic                         err_we,
    input  logic                         err_clr
);
    localparam int NUM_SLOTS = 2**SLOT_BITS;
    typedef enum logic {S_RUN, S_WAIT} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n, w;
    logic [SLOT_BITS-1:0] slot, sel_slot;
    logic mapped, sel_map, fsm_rdy, err_hit;
    logic [DW-1:0] rdata [NUM_SLOTS];
    assign slot = cpu_ab[AW-1 -: SLOT_BITS];
    assign mapped = SLOT_EN[slot];
    assign w = mapped ? WAIT_CFG[{slot, 2'b00} +: 4] : 4'd0;
    assign slot_cs = mapped ? {{(NUM_SLOTS-1){1'b0}}, 1'b1} << slot : '0;
    assign slot_ab = cpu_ab[AW-SLOT_BITS-1:0];
    assign slot_wdata = cpu_do;
    assign cpu_rdy = fsm_rdy & ~hold_in & ~reset;
    assign slot_we = cpu_we & cpu_rdy & mapped;
    assign err_hit = cpu_rdy & ~mapped;
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_rd
        assign rdata[i] = slot_rdata[i*DW +: DW];
    end
    assign cpu_di = sel_map ? rdata[sel_slot] : UNMAPPED_DATA;
    // The final WAIT cycle leaves only when the CPU actually sees RDY; hold stalls it there.
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        fsm_rdy = 1'b1;
        if (state == S_RUN) begin
            if (w != 4'd0) begin
                fsm_rdy = 1'b0;
                state_n = S_WAIT;
                cnt_n = w - 4'd1;
            end
        end else if (cnt != 4'd0) begin
            fsm_rdy = 1'b0;
            cnt_n = cnt - 4'd1;
        end else begin
            state_n = hold_in ? S_WAIT : S_RUN;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RUN;
            cnt <= 4'd0;
            sel_slot <= '0;
            sel_map <= 1'b1;
            bus_err <= 1'b0;
            err_addr <= '0;
            err_we <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            sel_slot <= slot;
            sel_map <= mapped;
            bus_err <= err_hit | (bus_err & ~err_clr);
            if (err_hit & (~bus_err | err_clr)) begin
                err_addr <= cpu_ab;
                err_we <= cpu_we;
            end
        end
    end
endmodule
